hvac_zone_ctrl: RTL and testbench

Multi-zone HVAC controller: the parametrised successor of the single-zone heater/pump/fan controller. It runs one independent state machine per zone. Each zone compares an unsigned temperature sample against shared setpoints with hysteresis. It enforces a minimum on-time for heater and pump and runs a fan post-purge after every heat or cool cycle. Sits between the sensor/keypad front end and the actuator drivers.

---
 rtl/hvac_zone_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_hvac_zone_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hvac_zone_ctrl.sv
// -----------------------------------------------------------------------------
// hvac_zone_ctrl
//
// Multi-zone HVAC controller. Each zone runs its own small state machine that
// compares its registered temperature sample against the shared setpoints
// (with hysteresis). It holds the heater/pump on for a minimum time and runs
// a fan post-purge after every heat or cool cycle.
//
// Optional feature macro: HVAC_PURGE_EN
//   defined   : HEAT/COOL exit through PURGE (FAN_RUN fan cycles)
//   undefined : HEAT/COOL exit straight to VENT (keypad held) or IDLE
//
// Parameters
//   ZONES   number of independent zones (>=1)
//   TW      temperature / setpoint width
//   HYST    hysteresis in temperature LSBs
//   MIN_ON  minimum cycles spent in HEAT or COOL (>=1)
//   FAN_RUN post-purge fan cycles (>=1)
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   temp     zone temperatures, zone z at [z*TW +: TW]
//   set_lo   heat threshold
//   set_hi   cool threshold
//   keypad   per-zone fan request (level)
//   den      per-zone heater enable
//   bom      per-zone pump/cooler enable
//   quat     per-zone fan enable
//   cfg_err  setpoints invalid (set_lo >= set_hi), registered
// -----------------------------------------------------------------------------
module hvac_zone_ctrl #(
   parameter int ZONES   = 4,
   parameter int TW      = 8,
   parameter int HYST    = 2,
   parameter int MIN_ON  = 16,
   parameter int FAN_RUN = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ZONES*TW-1:0]   temp,
   input  logic [TW-1:0]         set_lo,
   input  logic [TW-1:0]         set_hi,
   input  logic [ZONES-1:0]      keypad,
   output logic [ZONES-1:0]      den,
   output logic [ZONES-1:0]      bom,
   output logic [ZONES-1:0]      quat,
   output logic                  cfg_err
);

   localparam int CNT_MAX = (MIN_ON > FAN_RUN) ? MIN_ON : FAN_RUN;
   localparam int CW      = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

   localparam logic [CW-1:0] MIN_ON_LD = CW'(MIN_ON - 1);
`ifdef HVAC_PURGE_EN
   localparam logic [CW-1:0] FAN_LD    = CW'(FAN_RUN - 1);
`endif
   localparam logic [TW:0]   HYST_W    = (TW + 1)'(HYST);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_COOL  = 3'd1,
      ST_HEAT  = 3'd2,
      ST_VENT  = 3'd3,
      ST_PURGE = 3'd4
   } state_t;

   // ------------------------------------------------------------------
   // Input registers and setpoint check. The FSMs only ever see these.
   // ------------------------------------------------------------------
   logic [ZONES*TW-1:0] temp_q;
   logic [ZONES-1:0]    keypad_q;
   logic [TW-1:0]       set_lo_q;
   logic [TW-1:0]       set_hi_q;
   logic                cfg_err_q;
   logic                cfg_err_d;

   // Judged on the registered setpoints, so it lags the pins by two edges.
   assign cfg_err_d = (set_lo_q >= set_hi_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         temp_q    <= '0;
         keypad_q  <= '0;
         set_lo_q  <= '0;
         set_hi_q  <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         temp_q    <= temp;
         keypad_q  <= keypad;
         set_lo_q  <= set_lo;
         set_hi_q  <= set_hi;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign cfg_err = cfg_err_q;

   // ------------------------------------------------------------------
   // One independent FSM + counter per zone
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < ZONES; gi++) begin : g_zone
         logic [TW:0]   t_w;
         logic          hot;
         logic          cold;
         logic          cool_done;
         logic          heat_done;
         state_t        state_q;
         state_t        state_d;
         logic [CW-1:0] cnt_q;
         logic [CW-1:0] cnt_d;

         // One extra bit so adding HYST can never wrap.
         assign t_w       = {1'b0, temp_q[gi*TW +: TW]};
         assign hot       = t_w > {1'b0, set_hi_q};
         assign cold      = t_w < {1'b0, set_lo_q};
         assign cool_done = (t_w + HYST_W) <= {1'b0, set_hi_q};
         assign heat_done = t_w >= ({1'b0, set_lo_q} + HYST_W);

         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
               ST_IDLE, ST_VENT: begin
                  if (hot) begin
                     state_d = ST_COOL;
                     cnt_d   = MIN_ON_LD;
                  end else if (cold) begin
                     state_d = ST_HEAT;
                     cnt_d   = MIN_ON_LD;
                  end else if (state_q == ST_IDLE && keypad_q[gi]) begin
                     state_d = ST_VENT;
                  end else if (state_q == ST_VENT && !keypad_q[gi]) begin
                     state_d = ST_IDLE;
                  end
               end
               ST_COOL, ST_HEAT: begin
                  if (cnt_q != '0) begin
                     cnt_d = cnt_q - 1'b1;
                  end else if ((state_q == ST_COOL) ? cool_done : heat_done) begin
`ifdef HVAC_PURGE_EN
                     state_d = ST_PURGE;
                     cnt_d   = FAN_LD;
`else
                     state_d = keypad_q[gi] ? ST_VENT : ST_IDLE;
                     cnt_d   = '0;
`endif
                  end
               end
`ifdef HVAC_PURGE_EN
               ST_PURGE: begin
                  // Demand is deliberately ignored until the purge ends.
                  if (cnt_q != '0) begin
                     cnt_d = cnt_q - 1'b1;
                  end else begin
                     state_d = keypad_q[gi] ? ST_VENT : ST_IDLE;
                  end
               end
`endif
               default: begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            endcase

            // Bad setpoints park every zone, overriding min-on and purge.
            if (cfg_err_q) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
            end
         end

         // Outputs come straight from the state register (plus keypad_q,
         // which is also cleared by reset) so reset blanks them at once.
         assign den[gi]  = (state_q == ST_HEAT);
         assign bom[gi]  = (state_q == ST_COOL);
         assign quat[gi] = (state_q == ST_VENT) || (state_q == ST_PURGE) ||
                           (((state_q == ST_HEAT) || (state_q == ST_COOL)) && keypad_q[gi]);
      end
   endgenerate

endmodule

// File: tb/tb_hvac_zone_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hvac_zone_ctrl
//
// Directed bench for hvac_zone_ctrl with ZONES=2, TW=8, HYST=2, MIN_ON=4,
// FAN_RUN=3, set_lo=20, set_hi=30. Expected outputs for each cycle are pushed
// to a scoreboard queue as the stimulus is driven and popped once the DUT has
// produced that cycle's outputs. Purge expectations follow HVAC_PURGE_EN.
// -----------------------------------------------------------------------------
module tb_hvac_zone_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] temp;
   logic [7:0]  set_lo;
   logic [7:0]  set_hi;
   logic [1:0]  keypad;
   logic [1:0]  den;
   logic [1:0]  bom;
   logic [1:0]  quat;
   logic        cfg_err;

   hvac_zone_ctrl #(
      .ZONES   (2),
      .TW      (8),
      .HYST    (2),
      .MIN_ON  (4),
      .FAN_RUN (3)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .temp    (temp),
      .set_lo  (set_lo),
      .set_hi  (set_hi),
      .keypad  (keypad),
      .den     (den),
      .bom     (bom),
      .quat    (quat),
      .cfg_err (cfg_err)
   );

   always #5 clk = ~clk;

`ifdef HVAC_PURGE_EN
   localparam logic [1:0] PG0 = 2'b01;
`else
   localparam logic [1:0] PG0 = 2'b00;
`endif

   typedef struct {
      string      tag;
      logic [1:0] den;
      logic [1:0] bom;
      logic [1:0] quat;
      logic       cfg;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   task automatic push(input string tag, input logic [1:0] d, input logic [1:0] b,
                       input logic [1:0] q, input logic c);
      exp_t e;
      e.tag = tag; e.den = d; e.bom = b; e.quat = q; e.cfg = c;
      sb.push_back(e);
   endtask

   task automatic check_now();
      exp_t e;
      e = sb.pop_front();
      n_assert++;
      assert (den === e.den) else begin
         n_fail++;
         $error("FAIL %s den observed=%b expected=%b", e.tag, den, e.den);
      end
      n_assert++;
      assert (bom === e.bom) else begin
         n_fail++;
         $error("FAIL %s bom observed=%b expected=%b", e.tag, bom, e.bom);
      end
      n_assert++;
      assert (quat === e.quat) else begin
         n_fail++;
         $error("FAIL %s quat observed=%b expected=%b", e.tag, quat, e.quat);
      end
      n_assert++;
      assert (cfg_err === e.cfg) else begin
         n_fail++;
         $error("FAIL %s cfg_err observed=%b expected=%b", e.tag, cfg_err, e.cfg);
      end
      $display("t=%0t %s den=%b bom=%b quat=%b cfg_err=%b", $time, e.tag, den, bom, quat, cfg_err);
   endtask

   // Expected outputs after the next rising edge.
   task automatic cyc(input string tag, input logic [1:0] d, input logic [1:0] b,
                      input logic [1:0] q, input logic c);
      push(tag, d, b, q, c);
      @(posedge clk);
      #1;
      check_now();
   endtask

   // Input registers leave reset at 0, so the first edge sees 0 >= 0 and
   // flags cfg_err for one cycle before the real setpoints arrive.
   task automatic after_reset(input string tag);
      cyc({tag, "_e1"}, 2'b00, 2'b00, 2'b00, 1'b1);
      cyc({tag, "_e2"}, 2'b00, 2'b00, 2'b00, 1'b0);
      cyc({tag, "_e3"}, 2'b00, 2'b00, 2'b00, 1'b0);
   endtask

   initial begin
      temp   = {8'd25, 8'd25};
      set_lo = 8'd20;
      set_hi = 8'd30;
      keypad = 2'b00;
      rst    = 1'b1;

      // ---------------- reset ----------------
      cyc("reset_a", 2'b00, 2'b00, 2'b00, 1'b0);
      cyc("reset_b", 2'b00, 2'b00, 2'b00, 1'b0);
      rst = 1'b0;
      after_reset("post_reset");

      // ---------------- zone0 cool cycle ----------------
      temp[7:0] = 8'd35;
      cyc("cool_capture", 2'b00, 2'b00, 2'b00, 1'b0);
      temp[7:0] = 8'd28;
      for (int i = 0; i < 4; i++) cyc("cool_min_on", 2'b00, 2'b01, 2'b00, 1'b0);
      for (int i = 0; i < 3; i++) cyc("cool_purge", 2'b00, 2'b00, PG0, 1'b0);
      cyc("cool_done_idle", 2'b00, 2'b00, 2'b00, 1'b0);

      // ---------------- zone1 heat with keypad ----------------
      temp[15:8] = 8'd15;
      keypad     = 2'b10;
      cyc("heat_capture", 2'b00, 2'b00, 2'b00, 1'b0);
      temp[15:8] = 8'd21;
      for (int i = 0; i < 5; i++) cyc("heat_on", 2'b10, 2'b00, 2'b10, 1'b0);
      temp[15:8] = 8'd22;
      cyc("heat_hyst_hold", 2'b10, 2'b00, 2'b10, 1'b0);
      // Purge and the following VENT both drive quat while keypad is held.
      for (int i = 0; i < 3; i++) cyc("heat_purge", 2'b00, 2'b00, 2'b10, 1'b0);
      cyc("heat_vent", 2'b00, 2'b00, 2'b10, 1'b0);
      keypad = 2'b00;
      cyc("vent_release_lag", 2'b00, 2'b00, 2'b10, 1'b0);
      cyc("vent_to_idle", 2'b00, 2'b00, 2'b00, 1'b0);

      // ---------------- cfg_err override ----------------
      temp[7:0] = 8'd35;
      cyc("cfg_capture", 2'b00, 2'b00, 2'b00, 1'b0);
      cyc("cfg_cool", 2'b00, 2'b01, 2'b00, 1'b0);
      set_lo = 8'd31;
      cyc("cfg_lo_captured", 2'b00, 2'b01, 2'b00, 1'b0);
      // Zone1 (22 < 31) starts heating on this edge; forced idle next edge.
      cyc("cfg_err_rise", 2'b10, 2'b01, 2'b00, 1'b1);
      cyc("cfg_forced_idle", 2'b00, 2'b00, 2'b00, 1'b1);
      cyc("cfg_hold", 2'b00, 2'b00, 2'b00, 1'b1);
      set_lo = 8'd20;
      cyc("cfg_restore_a", 2'b00, 2'b00, 2'b00, 1'b1);
      cyc("cfg_restore_b", 2'b00, 2'b00, 2'b00, 1'b0);
      cyc("cfg_resume_cool", 2'b00, 2'b01, 2'b00, 1'b0);
      temp[7:0] = 8'd25;
      for (int i = 0; i < 3; i++) cyc("resume_min_on", 2'b00, 2'b01, 2'b00, 1'b0);
      for (int i = 0; i < 3; i++) cyc("resume_purge", 2'b00, 2'b00, PG0, 1'b0);
      cyc("resume_idle", 2'b00, 2'b00, 2'b00, 1'b0);

      // ---------------- reset mid-operation ----------------
      temp = {8'd10, 8'd10};
      cyc("both_capture", 2'b00, 2'b00, 2'b00, 1'b0);
      cyc("both_heat_a", 2'b11, 2'b00, 2'b00, 1'b0);
      cyc("both_heat_b", 2'b11, 2'b00, 2'b00, 1'b0);
      rst = 1'b1;
      #1;
      push("rst_immediate", 2'b00, 2'b00, 2'b00, 1'b0);
      check_now();
      cyc("rst_held", 2'b00, 2'b00, 2'b00, 1'b0);
      temp = {8'd25, 8'd25};
      rst  = 1'b0;
      after_reset("rst_release");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
